// File: rtl/ota_trim_sar_ctrl.sv
// Successive-approximation offset-trim controller for the on-chip OTA.
// Binary-searches the trim-DAC code MSB first, judging each trial by the synchronised comparator.
module ota_trim_sar_ctrl #(
    parameter int TRIM_W      = 6,
    parameter int SETTLE_CYC  = 16,
    parameter int SYNC_STAGES = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              abort,
    input  logic              man_load,
    input  logic [TRIM_W-1:0] man_code,
    input  logic              cmp_in,
    output logic [TRIM_W-1:0] trim_code,
    output logic              cal_en,
    output logic              busy,
    output logic              done
);
    localparam int IDX_W = (TRIM_W > 2) ? $clog2(TRIM_W) : 1;
    localparam logic [TRIM_W-1:0] MIDSCALE = {1'b1, {(TRIM_W-1){1'b0}}};
    localparam logic [7:0] CNT_LAST = 8'(SETTLE_CYC - 1);

    typedef enum logic [2:0] {IDLE, PREP, TRIAL, SETTLE, DECIDE, FINISH} state_t;

    state_t                 state;
    logic [TRIM_W-1:0]      work;
    logic [TRIM_W-1:0]      result;
    logic [TRIM_W-1:0]      decided;
    logic [IDX_W-1:0]       idx;
    logic [7:0]             cnt;
    logic [SYNC_STAGES-1:0] sync;
    logic                   cmp_s;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) sync <= '0;
        else        sync <= {sync[SYNC_STAGES-2:0], cmp_in};
    end
    assign cmp_s = sync[SYNC_STAGES-1];

    // Work register with the bit under trial resolved by the comparator.
    always_comb begin
        decided      = work;
        decided[idx] = cmp_s;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            work   <= '0;
            result <= MIDSCALE;
            idx    <= '0;
            cnt    <= '0;
            busy   <= 1'b0;
            done   <= 1'b0;
        end else begin
            done <= 1'b0;
            if (abort && state != IDLE) begin
                state <= IDLE;
                busy  <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        if (start) begin
                            state <= PREP;
                            work  <= '0;
                            idx   <= IDX_W'(TRIM_W - 1);
                            cnt   <= '0;
                            busy  <= 1'b1;
                        end else if (man_load) begin
                            result <= man_code;
                        end
                    end
                    PREP: begin
                        if (cnt == CNT_LAST) state <= TRIAL;
                        else                 cnt   <= cnt + 8'd1;
                    end
                    TRIAL: begin
                        work[idx] <= 1'b1;
                        cnt       <= '0;
                        state     <= SETTLE;
                    end
                    SETTLE: begin
                        if (cnt == CNT_LAST) state <= DECIDE;
                        else                 cnt   <= cnt + 8'd1;
                    end
                    DECIDE: begin
                        work <= decided;
                        if (idx == '0) begin
                            result <= decided;
                            busy   <= 1'b0;
                            done   <= 1'b1;
                            state  <= FINISH;
                        end else begin
                            idx   <= idx - 1'b1;
                            state <= TRIAL;
                        end
                    end
                    FINISH:  state <= IDLE;
                    default: state <= IDLE;
                endcase
            end
        end
    end

    // While searching the DAC sees the trial code; otherwise the held result.
    assign trim_code = busy ? work : result;
    assign cal_en    = busy;
endmodule

// File: tb/tb_ota_trim_sar_ctrl.sv
// Bench for ota_trim_sar_ctrl: per-cycle comparison against a timeline model of the search,
// plus literal checks on trial codes, final codes and done timing.
module tb_ota_trim_sar_ctrl;
    localparam int TW = 6;
    localparam int SC = 16;
    localparam int DONE_E = SC + TW * (SC + 2);   // 124: edge after which done is high

    logic          clk = 1'b0, rst_n = 1'b0;
    logic          start = 1'b0, abort = 1'b0, man_load = 1'b0;
    logic [TW-1:0] man_code = '0;
    logic          cmp_in;
    logic [TW-1:0] trim_code;
    logic          cal_en, busy, done;

    int cmp_mode = 0;   // 0: code <= thr, 1: tied 1, 2: tied 0
    int thr = 37;
    int total = 0, bad = 0;

    ota_trim_sar_ctrl #(.TRIM_W(TW), .SETTLE_CYC(SC), .SYNC_STAGES(2)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .man_load(man_load),
        .man_code(man_code), .cmp_in(cmp_in), .trim_code(trim_code), .cal_en(cal_en),
        .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    assign cmp_in = (cmp_mode == 1) ? 1'b1 : (cmp_mode == 2) ? 1'b0 : (int'(trim_code) <= thr);

    task automatic chk(input string nm, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic bit cmp_fn(input int code);
        if (cmp_mode == 1) return 1'b1;
        if (cmp_mode == 2) return 1'b0;
        return code <= thr;
    endfunction

    // Model: m_e = edges since the start-sampling edge (-1 when idle).
    int m_e = -1;
    int m_res = 32;
    int m_tr[TW];
    int m_w[TW+1];

    always @(posedge clk or negedge rst_n) begin : model
        int w, t;
        if (!rst_n) begin
            m_e   <= -1;
            m_res <= 32;
        end else if (m_e < 0) begin
            if (start) begin
                m_e    <= 0;
                w      = 0;
                m_w[0] <= 0;
                for (int k = 0; k < TW; k++) begin
                    t = w | (1 << (TW - 1 - k));
                    m_tr[k] <= t;
                    if (cmp_fn(t)) w = t;
                    m_w[k+1] <= w;
                end
            end else if (man_load) begin
                m_res <= int'(man_code);
            end
        end else if (abort || m_e == DONE_E) begin
            m_e <= -1;
        end else begin
            m_e <= m_e + 1;
            if (m_e + 1 == DONE_E) m_res <= m_w[TW];
        end
    end

    // Code on the DAC after edge e of a run: zero while preparing, then each trial code
    // for its trial+settle span, then one cycle of the decided value.
    function automatic int exp_code(input int e);
        int k, r;
        if (e <= SC) return 0;
        k = (e - SC - 1) / (SC + 2);
        r = (e - SC - 1) % (SC + 2);
        if (r <= SC) return m_tr[k];
        return m_w[k+1];
    endfunction

    always @(posedge clk) begin
        int eb, ed, et;
        #1;
        eb = (m_e >= 0 && m_e < DONE_E) ? 1 : 0;
        ed = (m_e == DONE_E) ? 1 : 0;
        et = eb ? exp_code(m_e) : m_res;
        chk("busy", int'(busy), eb);
        chk("cal_en", int'(cal_en), eb);
        chk("done", int'(done), ed);
        chk("trim_code", int'(trim_code), et);
    end

    int obs_tr[TW];
    int done_e;

    task automatic run_cal(input int hold_lo, input int hold_hi);
        @(negedge clk);
        start  = 1'b1;
        done_e = -1;
        for (int n = 0; n < 300 && done_e < 0; n++) begin
            @(posedge clk);
            #2;
            start    = (n >= hold_lo && n < hold_hi);
            man_load = 1'b0;
            if (n >= SC + 1 && (n - SC - 1) % (SC + 2) == 0 && (n - SC - 1) / (SC + 2) < TW)
                obs_tr[(n - SC - 1) / (SC + 2)] = int'(trim_code);
            if (done) done_e = n;
        end
        start = 1'b0;
        chk("done_edge", done_e, DONE_E);
    endtask

    task automatic count_done(input int cycles, output int cnt);
        cnt = 0;
        repeat (cycles) begin
            @(posedge clk);
            #2;
            if (done) cnt++;
        end
    endtask

    initial begin : stim
        int exp_tr[TW];
        int dcnt;
        exp_tr = '{32, 48, 40, 36, 38, 37};

        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (200) @(negedge clk);
        chk("idle_trim", int'(trim_code), 32);

        // Threshold comparator at 37
        run_cal(0, 0);
        for (int k = 0; k < TW; k++) chk("trial_code", obs_tr[k], exp_tr[k]);
        @(negedge clk);
        chk("result_37", int'(trim_code), 37);

        cmp_mode = 1;
        run_cal(0, 0);
        @(negedge clk);
        chk("result_tied1", int'(trim_code), 63);
        cmp_mode = 2;
        run_cal(0, 0);
        @(negedge clk);
        chk("result_tied0", int'(trim_code), 0);
        cmp_mode = 0;

        // Manual load, then abort at edge 50 of a run
        @(negedge clk);
        man_code = 6'd9;
        man_load = 1'b1;
        @(posedge clk);
        #1;
        chk("man_load", int'(trim_code), 9);
        @(negedge clk);
        man_load = 1'b0;
        start    = 1'b1;
        for (int n = 0; n < 50; n++) begin
            @(posedge clk);
            #2;
            start = 1'b0;
            if (n == 49) abort = 1'b1;
        end
        @(posedge clk);
        #1;
        chk("abort_busy", int'(busy), 0);
        chk("abort_trim", int'(trim_code), 9);
        @(negedge clk);
        abort = 1'b0;
        count_done(150, dcnt);
        chk("abort_no_done", dcnt, 0);

        // start wins over man_load; start during busy ignored
        man_code = 6'd5;
        man_load = 1'b1;
        run_cal(30, 60);
        @(negedge clk);
        chk("start_wins", (trim_code == 6'd5) ? 1 : 0, 0);
        chk("start_wins_code", int'(trim_code), 37);
        count_done(150, dcnt);
        chk("single_done", dcnt, 0);

        // Asynchronous reset mid-SETTLE
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #2;
        start = 1'b0;
        repeat (24) @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        chk("async_rst_trim", int'(trim_code), 32);
        chk("async_rst_busy", int'(busy), 0);
        chk("async_rst_cal_en", int'(cal_en), 0);
        chk("async_rst_done", int'(done), 0);
        @(negedge clk);
        rst_n = 1'b1;
        run_cal(0, 0);
        @(negedge clk);
        chk("post_rst_result", int'(trim_code), 37);

        repeat (5) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
